// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
//   Shared definitions for the multicycle multiply/divide unit:
//   - operand width and iteration counts
//   - FSM state encoding
//   - radix-4 Booth operation codes and the window decoder
// -----------------------------------------------------------------------------
package multdiv_pkg;

   localparam int DATA_WIDTH = 32;

   // Iteration counts loaded into the 6-bit down-counter at a start edge.
   localparam logic [5:0] MULT_ITERS = 6'd16;
   localparam logic [5:0] DIV_ITERS  = 6'd32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MULT = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      BOOTH_NOP    = 3'd0,
      BOOTH_ADD_M  = 3'd1,
      BOOTH_ADD_2M = 3'd2,
      BOOTH_SUB_M  = 3'd3,
      BOOTH_SUB_2M = 3'd4
   } booth_op_e;

   // Window is {b(2i+1), b(2i), b(2i-1)} of the multiplier.
   function automatic booth_op_e booth_decode(input logic [2:0] win);
      booth_op_e op;
      case (win)
         3'b001, 3'b010: op = BOOTH_ADD_M;
         3'b011:         op = BOOTH_ADD_2M;
         3'b100:         op = BOOTH_SUB_2M;
         3'b101, 3'b110: op = BOOTH_SUB_M;
         default:        op = BOOTH_NOP;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// -----------------------------------------------------------------------------
// multdiv_unit_if
//   Operand / control / result bundle between the execute stage and the
//   multiply/divide unit.
//   master : drives data_operandA/B, ctrl_MULT, ctrl_DIV; receives results
//   slave  : the unit itself
// -----------------------------------------------------------------------------
interface multdiv_unit_if;

   logic [multdiv_pkg::DATA_WIDTH-1:0] data_operandA;
   logic [multdiv_pkg::DATA_WIDTH-1:0] data_operandB;
   logic                               ctrl_MULT;
   logic                               ctrl_DIV;
   logic [multdiv_pkg::DATA_WIDTH-1:0] data_result;
   logic                               data_exception;
   logic                               data_resultRDY;
   logic                               busy;

   modport master (
      output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      input  data_result, data_exception, data_resultRDY, busy
   );

   modport slave (
      input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
      output data_result, data_exception, data_resultRDY, busy
   );

endinterface

// File: rtl/multdiv_unit_booth_step.sv
// -----------------------------------------------------------------------------
// booth_step
//   Combinational radix-4 Booth digit generator.
//   window_i [2:0]  : Booth window of the multiplier
//   mcand_i  [32:0] : sign-extended multiplicand
//   addend_o [33:0] : signed addend (0, +M, +2M, -M or -2M)
// -----------------------------------------------------------------------------
module booth_step
   import multdiv_pkg::*;
(
   input  logic [2:0]  window_i,
   input  logic [32:0] mcand_i,
   output logic [33:0] addend_o
);

   logic [33:0] m1;
   logic [33:0] m2;

   always_comb begin
      m1       = {mcand_i[32], mcand_i};
      m2       = {mcand_i, 1'b0};
      addend_o = '0;
      case (booth_decode(window_i))
         BOOTH_ADD_M:  addend_o = m1;
         BOOTH_ADD_2M: addend_o = m2;
         BOOTH_SUB_M:  addend_o = ~m1 + 34'd1;
         BOOTH_SUB_2M: addend_o = ~m2 + 34'd1;
         default:      addend_o = '0;
      endcase
   end

endmodule

// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
//   Multicycle signed 32-bit multiply (radix-4 Booth, 16 steps) and divide
//   (non-restoring on magnitudes, 32 steps + sign fix-up).
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of multdiv_unit_if (operands, start pulses, result,
//           exception, one-cycle ready pulse, busy)
//   A start pulse in any state (including mid-operation) restarts the unit
//   with the new operands; ctrl_MULT has priority over ctrl_DIV.
// -----------------------------------------------------------------------------
module multdiv_unit
   import multdiv_pkg::*;
(
   input logic           clock,
   input logic           reset,
   multdiv_unit_if.slave bus
);

   state_e      state_q;
   logic [5:0]  cnt_q;

   // Multiplier: {acc[31:0], multiplier[31:0], guard}
   logic [64:0] prod_q;
   logic [64:0] prod_d;
   logic [32:0] mcand_q;

   // Divider: signed partial remainder, quotient/dividend shift register
   logic [33:0] rem_q;
   logic [33:0] rem_d;
   logic [31:0] quo_q;
   logic [31:0] quo_d;
   logic [32:0] dvsr_q;
   logic        neg_q;
   logic        dz_q;
   logic        dovf_q;

   logic [31:0] result_q;
   logic        exc_q;
   logic        rdy_q;
   logic        busy_q;

   logic        start;
   logic [33:0] addend;
   logic [33:0] booth_sum;
   logic [63:0] product;
   logic        mult_ovf;
   logic [33:0] rem_shift;
   logic [31:0] quo_signed;
   logic [31:0] abs_a;
   logic [31:0] abs_b;

   booth_step u_booth (
      .window_i (prod_q[2:0]),
      .mcand_i  (mcand_q),
      .addend_o (addend)
   );

   always_comb begin
      start = bus.ctrl_MULT | bus.ctrl_DIV;

      // Booth step: add into the sign-extended accumulator, then shift the
      // whole register right by two. The top two bits of the 34-bit sum are
      // redundant sign copies after the shift, so they drop out.
      booth_sum = {{2{prod_q[64]}}, prod_q[64:33]} + addend;
      prod_d    = {booth_sum, prod_q[32:2]};
      product   = prod_d[64:1];
      mult_ovf  = ~((&product[63:31]) | ~(|product[63:31]));

      // Non-restoring step: quotient bit is 1 whenever the new remainder is
      // non-negative, which yields the exact truncated quotient directly.
      rem_shift = {rem_q[32:0], quo_q[31]};
      rem_d     = rem_q[33] ? (rem_shift + {1'b0, dvsr_q})
                            : (rem_shift - {1'b0, dvsr_q});
      quo_d     = {quo_q[30:0], ~rem_d[33]};

      quo_signed = neg_q ? (~quo_q + 32'd1) : quo_q;

      // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude.
      abs_a = bus.data_operandA[31] ? (~bus.data_operandA + 32'd1) : bus.data_operandA;
      abs_b = bus.data_operandB[31] ? (~bus.data_operandB + 32'd1) : bus.data_operandB;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         neg_q    <= 1'b0;
         dz_q     <= 1'b0;
         dovf_q   <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         rdy_q <= 1'b0;
         if (start) begin
            busy_q <= 1'b1;
            if (bus.ctrl_MULT) begin
               state_q <= ST_MULT;
               cnt_q   <= MULT_ITERS;
               prod_q  <= {32'd0, bus.data_operandB, 1'b0};
               mcand_q <= {bus.data_operandA[31], bus.data_operandA};
            end else begin
               state_q <= ST_DIV;
               cnt_q   <= DIV_ITERS;
               rem_q   <= '0;
               quo_q   <= abs_a;
               dvsr_q  <= {1'b0, abs_b};
               neg_q   <= bus.data_operandA[31] ^ bus.data_operandB[31];
               dz_q    <= (bus.data_operandB == 32'd0);
               dovf_q  <= (bus.data_operandA == 32'h8000_0000) &&
                          (bus.data_operandB == 32'hFFFF_FFFF);
            end
         end else begin
            case (state_q)
               ST_MULT: begin
                  prod_q <= prod_d;
                  cnt_q  <= (cnt_q != 6'd0) ? (cnt_q - 6'd1) : cnt_q;
                  if (cnt_q == 6'd1) begin
                     state_q  <= ST_DONE;
                     result_q <= product[31:0];
                     exc_q    <= mult_ovf;
                     rdy_q    <= 1'b1;
                  end
               end
               ST_DIV: begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= (cnt_q != 6'd0) ? (cnt_q - 6'd1) : cnt_q;
                  if (cnt_q == 6'd1) begin
                     state_q <= ST_FIX;
                  end
               end
               ST_FIX: begin
                  state_q <= ST_DONE;
                  rdy_q   <= 1'b1;
                  if (dz_q) begin
                     result_q <= '0;
                     exc_q    <= 1'b1;
                  end else if (dovf_q) begin
                     result_q <= 32'h8000_0000;
                     exc_q    <= 1'b1;
                  end else begin
                     result_q <= quo_signed;
                     exc_q    <= 1'b0;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
//   Directed bench for multdiv_unit. An arithmetic model (plain signed * and /)
//   predicts ready/busy/result/exception every cycle; directed operations also
//   check hand-computed results and latencies.
// -----------------------------------------------------------------------------
module tb_multdiv_unit;

   logic clock;
   logic reset;

   multdiv_unit_if bus ();

   multdiv_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [32:0] mult_model(input logic [31:0] a, input logic [31:0] b);
      longint p;
      logic [31:0] lo;
      logic ovf;
      p   = longint'($signed(a)) * longint'($signed(b));
      lo  = p[31:0];
      ovf = (p != longint'($signed(lo)));
      return {ovf, lo};
   endfunction

   function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b);
      int q;
      if (b == 32'd0) return {1'b1, 32'd0};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      return {1'b0, q};
   endfunction

   int unsigned edge_n = 0;
   bit          pend_v = 1'b0;
   int unsigned pend_due = 0;
   logic [31:0] pend_res;
   logic        pend_exc;
   logic        exp_rdy = 1'b0;
   logic        exp_busy = 1'b0;
   logic [31:0] exp_res = '0;
   logic        exp_exc = 1'b0;

   // Ready becomes visible 16 edges after a MULT start edge (cycle S+17) and
   // 33 edges after a DIV start edge (cycle S+34).
   always @(posedge clock) begin
      edge_n++;
      if (reset) begin
         pend_v   = 1'b0;
         exp_rdy  = 1'b0;
         exp_busy = 1'b0;
         exp_res  = '0;
         exp_exc  = 1'b0;
      end else begin
         exp_rdy = 1'b0;
         if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            pend_v = 1'b1;
            if (bus.ctrl_MULT) begin
               {pend_exc, pend_res} = mult_model(bus.data_operandA, bus.data_operandB);
               pend_due = edge_n + 16;
            end else begin
               {pend_exc, pend_res} = div_model(bus.data_operandA, bus.data_operandB);
               pend_due = edge_n + 33;
            end
         end else if (pend_v && edge_n == pend_due) begin
            exp_rdy = 1'b1;
            exp_res = pend_res;
            exp_exc = pend_exc;
            pend_v  = 1'b0;
         end
         exp_busy = pend_v || exp_rdy;
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("cyc_rdy",  {63'd0, bus.data_resultRDY}, {63'd0, exp_rdy});
         chk("cyc_busy", {63'd0, bus.busy},           {63'd0, exp_busy});
         chk("cyc_res",  {32'd0, bus.data_result},    {32'd0, exp_res});
         chk("cyc_exc",  {63'd0, bus.data_exception}, {63'd0, exp_exc});
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_MULT     = m;
      bus.ctrl_DIV      = d;
      @(negedge clock);
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
   endtask

   task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] res, input logic exc, input string name);
      int n;
      bit seen;
      issue(m, d, a, b);
      n    = 1;
      seen = 1'b0;
      while (!seen && n <= 60) begin
         if (bus.data_resultRDY) seen = 1'b1;
         else begin
            @(negedge clock);
            n++;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: no ready within 60 cycles", name);
      end else begin
         chk({name, "_lat"}, 64'(n), 64'(lat));
         chk({name, "_res"}, {32'd0, bus.data_result}, {32'd0, res});
         chk({name, "_exc"}, {63'd0, bus.data_exception}, {63'd0, exc});
      end
      $display("op %s: a=0x%08h b=0x%08h res=0x%08h exc=%0b lat=%0d", name, a, b,
               bus.data_result, bus.data_exception, n);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_MULT     = 1'b0;
      bus.ctrl_DIV      = 1'b0;
      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      chk("rst_res",  {32'd0, bus.data_result}, 64'd0);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      reset = 1'b0;
      @(negedge clock);

      // Multiply
      run_op(1, 0, 32'd7,          32'hFFFF_FFFA, 17, 32'hFFFF_FFD6, 1'b0, "mul_7x-6");
      run_op(1, 0, 32'h0001_0000,  32'h0001_0000, 17, 32'h0000_0000, 1'b1, "mul_ovf16");
      run_op(1, 0, 32'h8000_0000,  32'd1,         17, 32'h8000_0000, 1'b0, "mul_min_x1");
      run_op(1, 0, 32'h8000_0000,  32'h8000_0000, 17, 32'h0000_0000, 1'b1, "mul_minxmin");
      run_op(1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 17, 32'h0000_0001, 1'b0, "mul_-1x-1");
      run_op(1, 0, 32'hFFFF_FFFD,  32'h2000_0000, 17, 32'hA000_0000, 1'b0, "mul_neg_fit");
      run_op(1, 0, 32'h0000_FFFF,  32'h0000_FFFF, 17, 32'hFFFE_0001, 1'b1, "mul_ffff2");
      // Divide
      run_op(0, 1, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFD, 1'b0, "div_-7/2");
      run_op(0, 1, 32'd100,        32'hFFFF_FFF6, 34, 32'hFFFF_FFF6, 1'b0, "div_100/-10");
      run_op(0, 1, 32'd5,          32'd0,         34, 32'h0000_0000, 1'b1, "div_by0");
      run_op(0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 34, 32'h8000_0000, 1'b1, "div_min/-1");
      run_op(0, 1, 32'hFFFF_FF9C,  32'd7,         34, 32'hFFFF_FFF2, 1'b0, "div_-100/7");
      run_op(0, 1, 32'd7,          32'h8000_0000, 34, 32'h0000_0000, 1'b0, "div_7/min");
      run_op(0, 1, 32'h8000_0000,  32'd2,         34, 32'hC000_0000, 1'b0, "div_min/2");
      run_op(0, 1, 32'h7FFF_FFFF,  32'd1,         34, 32'h7FFF_FFFF, 1'b0, "div_max/1");

      // Abort: DIV 9/3 restarted by MULT 3x4 at S+10
      issue(0, 1, 32'd9, 32'd3);
      repeat (9) @(negedge clock);
      run_op(1, 0, 32'd3, 32'd4, 17, 32'd12, 1'b0, "abort_mul3x4");
      repeat (40) @(negedge clock);

      // Reset at S+5 of a MULT
      issue(1, 0, 32'h0000_1234, 32'h0000_0010);
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_mid_res",  {32'd0, bus.data_result},    64'd0);
      chk("rst_mid_exc",  {63'd0, bus.data_exception}, 64'd0);
      chk("rst_mid_rdy",  {63'd0, bus.data_resultRDY}, 64'd0);
      chk("rst_mid_busy", {63'd0, bus.busy},           64'd0);
      reset = 1'b0;
      repeat (30) @(negedge clock);

      // Both start pulses: MULT wins
      run_op(1, 1, 32'd5, 32'd6, 17, 32'd30, 1'b0, "both_ctrl");
      // Back-to-back starts issued in the ready cycle
      run_op(0, 1, 32'd1000, 32'd3, 34, 32'd333, 1'b0, "b2b_div");
      run_op(1, 0, 32'hFFFF_FFFE, 32'd21, 17, 32'hFFFF_FFD6, 1'b0, "b2b_mul");
      repeat (5) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
